// File: rtl/mem_arb_pkg.sv
// Shared types and default constants for the memory access arbiter.
// Build option: MEM_ARB_RR_EN selects round-robin conflict resolution.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_D  = 1'b1
  } req_id_e;

  localparam logic [31:0] RAM_BASE_DEF  = 32'h1001_0000;
  localparam logic [31:0] RAM_BYTES_DEF = 32'd256;

endpackage

// File: rtl/mem_access_arbiter_arb2.sv
// Two-way winner select between the fetch and data requesters.
// Build option: MEM_ARB_RR_EN adds a "last granted" pointer for round-robin;
// without it, data always wins a conflict and no pointer state exists.
import mem_arb_pkg::*;

module arb2 (
`ifdef MEM_ARB_RR_EN
  input  logic    i_clk,
  input  logic    i_rst,
  input  logic    i_take,
`endif
  input  logic    i_req_if,
  input  logic    i_req_d,
  output logic    o_any,
  output req_id_e o_win
);

`ifdef MEM_ARB_RR_EN
  logic r_last_d;

  // Remember who won the most recent grant; reset says "data last" so fetch wins first
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_last_d <= 1'b1;
    end else if (i_take) begin
      r_last_d <= (o_win == REQ_D);
    end else begin
      r_last_d <= r_last_d;
    end
  end

  // Conflict goes to the requester not granted last; a lone request always wins
  always_comb begin
    o_any = i_req_if | i_req_d;
    o_win = REQ_IF;
    if (i_req_if && i_req_d) begin
      o_win = r_last_d ? REQ_IF : REQ_D;
    end else if (i_req_d) begin
      o_win = REQ_D;
    end else begin
      o_win = REQ_IF;
    end
  end
`else
  // Fixed priority: data beats fetch whenever it is requesting
  always_comb begin
    o_any = i_req_if | i_req_d;
    if (i_req_d) begin
      o_win = REQ_D;
    end else begin
      o_win = REQ_IF;
    end
  end
`endif

endmodule

// File: rtl/mem_access_arbiter.sv
// Arbitrates the fetch and data ports onto the single memory-system port.
// One access every two cycles: ISSUE drives the address (and the write
// strobe for legal RAM writes), RESP captures read data and re-arbitrates.
// Build option: MEM_ARB_RR_EN switches conflicts to round-robin.
import mem_arb_pkg::*;

module mem_access_arbiter #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RAM_BASE   = DATA_WIDTH'(RAM_BASE_DEF),
  parameter logic [DATA_WIDTH-1:0] RAM_BYTES  = DATA_WIDTH'(RAM_BYTES_DEF)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  if_req_i,
  input  logic [DATA_WIDTH-1:0] if_addr_i,
  output logic                  if_gnt_o,
  output logic                  if_rvalid_o,
  output logic [DATA_WIDTH-1:0] if_rdata_o,
  input  logic                  d_req_i,
  input  logic                  d_we_i,
  input  logic [DATA_WIDTH-1:0] d_addr_i,
  input  logic [DATA_WIDTH-1:0] d_wdata_i,
  output logic                  d_gnt_o,
  output logic                  d_rvalid_o,
  output logic [DATA_WIDTH-1:0] d_rdata_o,
  output logic                  d_err_o,
  output logic                  mem_we_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  busy_o
);

  state_e                r_state;
  req_id_e               r_id;
  logic                  r_we;
  logic [DATA_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_if_gnt;
  logic                  r_d_gnt;
  logic                  r_if_rvalid;
  logic                  r_d_rvalid;
  logic [DATA_WIDTH-1:0] r_if_rdata;
  logic [DATA_WIDTH-1:0] r_d_rdata;
  logic                  r_d_err;
  logic                  r_busy;

  logic                  w_any;
  req_id_e               w_win;
  logic                  w_take;
  logic                  w_in_ram;
  logic                  w_nxt_we;
  logic [DATA_WIDTH-1:0] w_nxt_addr;
  logic [DATA_WIDTH-1:0] w_nxt_wdata;

  arb2 u_arb2 (
`ifdef MEM_ARB_RR_EN
    .i_clk    (clk_i),
    .i_rst    (reset_i),
    .i_take   (w_take),
`endif
    .i_req_if (if_req_i),
    .i_req_d  (d_req_i),
    .o_any    (w_any),
    .o_win    (w_win)
  );

  // Requests are only sampled in IDLE and RESP; a grant is taken whenever one is pending there
  always_comb begin
    if ((r_state == IDLE) || (r_state == RESP)) begin
      w_take = w_any;
    end else begin
      w_take = 1'b0;
    end
  end

  // Fields to latch for the arbitration winner; fetch is always a read with zero write data
  always_comb begin
    if (w_win == REQ_D) begin
      w_nxt_addr  = d_addr_i;
      w_nxt_we    = d_we_i;
      w_nxt_wdata = d_wdata_i;
    end else begin
      w_nxt_addr  = if_addr_i;
      w_nxt_we    = 1'b0;
      w_nxt_wdata = {DATA_WIDTH{1'b0}};
    end
  end

  // RAM window check on the latched address; subtract first so the window may end at the top of memory
  always_comb begin
    if ((r_addr >= RAM_BASE) && ((r_addr - RAM_BASE) < RAM_BYTES)) begin
      w_in_ram = 1'b1;
    end else begin
      w_in_ram = 1'b0;
    end
  end

  // Write strobe is decoded from state so that reset removes it immediately
  always_comb begin
    if ((r_state == ISSUE) && r_we && w_in_ram) begin
      mem_we_o = 1'b1;
    end else begin
      mem_we_o = 1'b0;
    end
  end

  // Access sequencer: latch winner, pulse grant, capture response, chain the next access
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state     <= IDLE;
      r_id        <= REQ_IF;
      r_we        <= 1'b0;
      r_addr      <= {DATA_WIDTH{1'b0}};
      r_wdata     <= {DATA_WIDTH{1'b0}};
      r_if_gnt    <= 1'b0;
      r_d_gnt     <= 1'b0;
      r_if_rvalid <= 1'b0;
      r_d_rvalid  <= 1'b0;
      r_if_rdata  <= {DATA_WIDTH{1'b0}};
      r_d_rdata   <= {DATA_WIDTH{1'b0}};
      r_d_err     <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_if_gnt    <= 1'b0;
      r_d_gnt     <= 1'b0;
      r_if_rvalid <= 1'b0;
      r_d_rvalid  <= 1'b0;
      r_d_err     <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_id     <= w_win;
            r_we     <= w_nxt_we;
            r_addr   <= w_nxt_addr;
            r_wdata  <= w_nxt_wdata;
            r_if_gnt <= (w_win == REQ_IF);
            r_d_gnt  <= (w_win == REQ_D);
            r_busy   <= 1'b1;
            r_state  <= ISSUE;
          end else begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        ISSUE: begin
          r_busy  <= 1'b1;
          r_state <= RESP;
        end
        RESP: begin
          if (r_id == REQ_D) begin
            r_d_rvalid <= 1'b1;
            r_d_err    <= r_we && !w_in_ram;
            if (!r_we) begin
              r_d_rdata <= mem_rdata_i;
            end else begin
              r_d_rdata <= r_d_rdata;
            end
          end else begin
            r_if_rvalid <= 1'b1;
            r_if_rdata  <= mem_rdata_i;
          end
          if (w_any) begin
            r_id     <= w_win;
            r_we     <= w_nxt_we;
            r_addr   <= w_nxt_addr;
            r_wdata  <= w_nxt_wdata;
            r_if_gnt <= (w_win == REQ_IF);
            r_d_gnt  <= (w_win == REQ_D);
            r_busy   <= 1'b1;
            r_state  <= ISSUE;
          end else begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign if_gnt_o    = r_if_gnt;
  assign if_rvalid_o = r_if_rvalid;
  assign if_rdata_o  = r_if_rdata;
  assign d_gnt_o     = r_d_gnt;
  assign d_rvalid_o  = r_d_rvalid;
  assign d_rdata_o   = r_d_rdata;
  assign d_err_o     = r_d_err;
  assign mem_addr_o  = r_addr;
  assign mem_wdata_o = r_wdata;
  assign busy_o      = r_busy;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed bench for mem_access_arbiter with a small RAM/ROM memory model.
// ROM words read as address XOR 32'hA5A5_5A5A; RAM is 64 words at 0x1001_0000.
module tb_mem_access_arbiter;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_gnt_o;
  logic        if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        d_req_i;
  logic        d_we_i;
  logic [31:0] d_addr_i;
  logic [31:0] d_wdata_i;
  logic        d_gnt_o;
  logic        d_rvalid_o;
  logic [31:0] d_rdata_o;
  logic        d_err_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i = 32'h0;
  logic        busy_o;

  logic [31:0] ram [0:63] = '{default: 32'h0};
  logic        rom_wr = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  mem_access_arbiter dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .if_req_i    (if_req_i),
    .if_addr_i   (if_addr_i),
    .if_gnt_o    (if_gnt_o),
    .if_rvalid_o (if_rvalid_o),
    .if_rdata_o  (if_rdata_o),
    .d_req_i     (d_req_i),
    .d_we_i      (d_we_i),
    .d_addr_i    (d_addr_i),
    .d_wdata_i   (d_wdata_i),
    .d_gnt_o     (d_gnt_o),
    .d_rvalid_o  (d_rvalid_o),
    .d_rdata_o   (d_rdata_o),
    .d_err_o     (d_err_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  // Memory system: read data valid one cycle after the address, writes on the edge
  always @(posedge clk) begin
    if ((mem_addr_o >= 32'h1001_0000) && (mem_addr_o < 32'h1001_0100))
      mem_rdata_i <= ram[mem_addr_o[7:2]];
    else
      mem_rdata_i <= mem_addr_o ^ 32'hA5A5_5A5A;
    if (mem_we_o) begin
      if ((mem_addr_o >= 32'h1001_0000) && (mem_addr_o < 32'h1001_0100))
        ram[mem_addr_o[7:2]] <= mem_wdata_o;
      else
        rom_wr <= 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    logic exp_d;
    logic prev_d;
    reset_i   = 1'b1;
    if_req_i  = 1'b0;
    if_addr_i = 32'h0;
    d_req_i   = 1'b0;
    d_we_i    = 1'b0;
    d_addr_i  = 32'h0;
    d_wdata_i = 32'h0;
    prev_d    = 1'b0;
    #12;
    // reset state
    chk("rst_gnt", {30'h0, if_gnt_o, d_gnt_o}, 32'h0);
    chk("rst_rvalid_err", {29'h0, if_rvalid_o, d_rvalid_o, d_err_o}, 32'h0);
    chk("rst_if_rdata", if_rdata_o, 32'h0);
    chk("rst_d_rdata", d_rdata_o, 32'h0);
    chk("rst_mem_addr", mem_addr_o, 32'h0);
    chk("rst_mem_wdata", mem_wdata_o, 32'h0);
    chk("rst_we_busy", {30'h0, mem_we_o, busy_o}, 32'h0);
    step();
    reset_i = 1'b0;
    step();
    chk("idle_busy", {31'h0, busy_o}, 32'h0);

    // simultaneous requests held for four accesses
    if_req_i  = 1'b1;
    if_addr_i = 32'h0040_0010;
    d_req_i   = 1'b1;
    d_we_i    = 1'b0;
    d_addr_i  = 32'h1001_0008;
    for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_RR_EN
      exp_d = (k % 2) == 1;
`else
      exp_d = 1'b1;
`endif
      step();
      chk("conf_d_gnt", {31'h0, d_gnt_o}, {31'h0, exp_d});
      chk("conf_if_gnt", {31'h0, if_gnt_o}, {31'h0, ~exp_d});
      if (k > 0) begin
        chk("conf_rvalid", {30'h0, if_rvalid_o, d_rvalid_o}, prev_d ? 32'h1 : 32'h2);
        if (prev_d)
          chk("conf_d_rdata", d_rdata_o, 32'h0000_0000);
        else
          chk("conf_if_rdata", if_rdata_o, 32'hA5E5_5A4A);
      end
      prev_d = exp_d;
      if (k == 3) begin
        if_req_i = 1'b0;
        d_req_i  = 1'b0;
      end
      step();
      chk("conf_gap_gnt", {30'h0, if_gnt_o, d_gnt_o}, 32'h0);
      chk("conf_gap_busy", {31'h0, busy_o}, 32'h1);
    end
    step();
    chk("conf_last_rvalid", {30'h0, if_rvalid_o, d_rvalid_o}, prev_d ? 32'h1 : 32'h2);
    chk("conf_end_busy", {31'h0, busy_o}, 32'h0);

    // single fetch from ROM
    if_req_i  = 1'b1;
    if_addr_i = 32'h0040_0004;
    step();
    chk("fetch_gnt", {31'h0, if_gnt_o}, 32'h1);
    chk("fetch_busy1", {31'h0, busy_o}, 32'h1);
    chk("fetch_addr", mem_addr_o, 32'h0040_0004);
    if_req_i = 1'b0;
    step();
    chk("fetch_busy2", {31'h0, busy_o}, 32'h1);
    chk("fetch_early_rvalid", {31'h0, if_rvalid_o}, 32'h0);
    step();
    chk("fetch_rvalid", {31'h0, if_rvalid_o}, 32'h1);
    chk("fetch_rdata", if_rdata_o, 32'hA5E5_5A5E);
    chk("fetch_busy3", {31'h0, busy_o}, 32'h0);
    step();
    chk("fetch_rvalid_pulse", {31'h0, if_rvalid_o}, 32'h0);

    // data write then read back
    d_req_i   = 1'b1;
    d_we_i    = 1'b1;
    d_addr_i  = 32'h1001_0008;
    d_wdata_i = 32'hDEAD_BEEF;
    step();
    chk("wr_gnt", {31'h0, d_gnt_o}, 32'h1);
    chk("wr_we_issue", {31'h0, mem_we_o}, 32'h1);
    chk("wr_wdata", mem_wdata_o, 32'hDEAD_BEEF);
    d_req_i = 1'b0;
    step();
    chk("wr_we_resp", {31'h0, mem_we_o}, 32'h0);
    step();
    chk("wr_rvalid_err", {30'h0, d_rvalid_o, d_err_o}, 32'h2);
    d_req_i = 1'b1;
    d_we_i  = 1'b0;
    step();
    chk("rd_we", {31'h0, mem_we_o}, 32'h0);
    d_req_i = 1'b0;
    step();
    step();
    chk("rd_rvalid_err", {30'h0, d_rvalid_o, d_err_o}, 32'h2);
    chk("rd_rdata", d_rdata_o, 32'hDEAD_BEEF);

    // illegal write into ROM space
    d_req_i   = 1'b1;
    d_we_i    = 1'b1;
    d_addr_i  = 32'h0040_0000;
    d_wdata_i = 32'h1111_2222;
    step();
    chk("ill_gnt", {31'h0, d_gnt_o}, 32'h1);
    chk("ill_we", {31'h0, mem_we_o}, 32'h0);
    d_req_i = 1'b0;
    step();
    step();
    chk("ill_rvalid_err", {30'h0, d_rvalid_o, d_err_o}, 32'h3);
    chk("ill_rdata_kept", d_rdata_o, 32'hDEAD_BEEF);
    step();
    chk("ill_err_pulse", {31'h0, d_err_o}, 32'h0);
    chk("ill_rom_untouched", {31'h0, rom_wr}, 32'h0);
    if_req_i  = 1'b1;
    if_addr_i = 32'h0040_0000;
    step();
    if_req_i = 1'b0;
    step();
    step();
    chk("ill_rom_read", if_rdata_o, 32'hA5E5_5A5A);

    // reset during the ISSUE cycle of a write
    d_req_i   = 1'b1;
    d_we_i    = 1'b1;
    d_addr_i  = 32'h1001_000C;
    d_wdata_i = 32'h1234_5678;
    step();
    chk("rmid_we_before", {31'h0, mem_we_o}, 32'h1);
    reset_i = 1'b1;
    d_req_i = 1'b0;
    #1;
    chk("rmid_we", {31'h0, mem_we_o}, 32'h0);
    chk("rmid_gnt_busy", {30'h0, d_gnt_o, busy_o}, 32'h0);
    chk("rmid_addr", mem_addr_o, 32'h0);
    chk("rmid_rdata", d_rdata_o, 32'h0);
    #1;
    reset_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("rmid_no_rvalid", {30'h0, if_rvalid_o, d_rvalid_o}, 32'h0);
      chk("rmid_idle", {31'h0, busy_o}, 32'h0);
    end
    d_req_i = 1'b1;
    d_we_i  = 1'b0;
    step();
    chk("rmid_next_gnt", {31'h0, d_gnt_o}, 32'h1);
    d_req_i = 1'b0;
    step();
    step();
    chk("rmid_next_rvalid", {31'h0, d_rvalid_o}, 32'h1);
    chk("rmid_not_committed", d_rdata_o, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_access_arbiter.md
# mem_access_arbiter

Sequencing and arbitration controller in front of the unified RAM/ROM memory system. Two requesters share the memory system's single address, write-data and read-data port: the instruction-fetch port (read-only) and the data port (read/write). The block grants one access at a time, drives the memory port and returns read data or a write acknowledge. It blocks illegal writes to non-RAM space.

## Interface
- DATA_WIDTH, 32, width of address and data buses
- RAM_BASE, 32'h1001_0000, first byte address of RAM region
- RAM_BYTES, 256, RAM region size in bytes (MEMORY_DEPTH*4)
- clk_i  in  1  rising-edge clock
- reset_i  in  1  asynchronous, active-high reset
- if_req_i  in  1  fetch request; held with if_addr_i until if_gnt_o
- if_addr_i  in  DATA_WIDTH  fetch byte address
- if_gnt_o  out  1  one-cycle grant pulse
- if_rvalid_o  out  1  one-cycle read-data-valid pulse
- if_rdata_o  out  DATA_WIDTH  fetched word, valid with if_rvalid_o
- d_req_i  in  1  data request; held with d_we_i, d_addr_i, d_wdata_i until d_gnt_o
- d_we_i  in  1  1 = write, 0 = read
- d_addr_i  in  DATA_WIDTH  data byte address
- d_wdata_i  in  DATA_WIDTH  write data
- d_gnt_o  out  1  one-cycle grant pulse
- d_rvalid_o  out  1  one-cycle completion pulse (reads and writes)
- d_rdata_o  out  DATA_WIDTH  read word, valid with d_rvalid_o on reads
- d_err_o  out  1  pulses with d_rvalid_o when the write was rejected
- mem_we_o  out  1  memory-system write enable
- mem_addr_o  out  DATA_WIDTH  memory-system address
- mem_wdata_o  out  DATA_WIDTH  memory-system write data
- mem_rdata_i  in  DATA_WIDTH  memory-system read data; valid one cycle after address
- busy_o  out  1  high whenever state is not IDLE

## Operation
- FSM: IDLE, ISSUE, RESP.
- IDLE: if any request, arbitrate, latch the winner's id, addr, we and wdata, then go to ISSUE. Otherwise stay.
- ISSUE: pulse winner's gnt_o. Drive mem_addr_o and mem_wdata_o from the latch. mem_we_o = latched we AND addr in [RAM_BASE, RAM_BASE+RAM_BYTES). Next state is RESP.
- RESP: memory outputs are held; mem_we_o = 0. At the clock edge:
  - register mem_rdata_i into the winner's rdata_o (reads only; the register is unchanged on writes);
  - set the winner's rvalid_o for the next cycle;
  - set d_err_o if the access was a write outside the RAM region.
- RESP exit: re-arbitrate and go to ISSUE if any request is pending, else go to IDLE.
- Arbitration conflict (both requests): fixed priority, data port wins. This is overridden by the Configuration section.
- A request that is already granted must be dropped by the requester after gnt. The arbiter never samples requests during ISSUE.
- Reads from any address are passed through. The memory system decodes RAM or ROM.
- Reset: state IDLE. All gnt, rvalid and err outputs are 0. rdata_o, mem_addr_o and mem_wdata_o are 0. mem_we_o is 0 and busy_o is 0. The round-robin pointer is set to "data last".
- Reset mid-access: the access is dropped with no rvalid. mem_we_o falls asynchronously, so a write commits only if a clock edge occurred in ISSUE before reset.

## Timing
- Request seen in cycle 0 (IDLE): gnt in cycle 1, mem_addr_o valid in cycles 1–2, rvalid/rdata in cycle 3.
- Back-to-back throughput: one access per 2 cycles. The next ISSUE overlaps the previous rvalid cycle.
- Idle-to-response latency is 3 cycles.
- Writes commit on the clock edge at the end of ISSUE.
- All outputs are registered except mem_we_o, which is decoded from state and the latched fields.

## Configuration
- MEM_ARB_RR_EN defined: conflicts resolve round-robin. The requester not granted last wins; the pointer updates on every grant. From reset, the first conflict goes to fetch.
- MEM_ARB_RR_EN undefined: fixed priority, data over fetch. The pointer logic is absent.

## Structure
- Package mem_arb_pkg holds:
  - state enum {IDLE, ISSUE, RESP};
  - requester id enum {REQ_IF, REQ_D};
  - default RAM_BASE/RAM_BYTES constants.
- Sub-module arb2: a 2-way combinational winner select plus the round-robin pointer flop under MEM_ARB_RR_EN.

## Test plan
- Single fetch: if_req_i=1, addr 0x0040_0004 in cycle 0 → if_gnt_o in cycle 1; if_rvalid_o in cycle 3 with the ROM word; busy_o high in cycles 1–2.
- Data write then read: write 0xDEAD_BEEF to 0x1001_0008, then read the same address → mem_we_o=1 only in the write's ISSUE cycle; read returns 0xDEAD_BEEF; d_err_o=0.
- Illegal write to 0x0040_0000 → mem_we_o stays 0; d_rvalid_o and d_err_o pulse together; a subsequent ROM read is unchanged.
- Simultaneous requests held for 4 accesses → without the macro, D,D,…; with MEM_ARB_RR_EN, alternating IF,D,IF,D; gnt pulses 2 cycles apart.
- reset_i asserted during ISSUE of a write → all outputs are 0 in the same cycle; no rvalid; state IDLE after release; the next request is serviced normally.
